bit_count_unit: RTL and testbench

BIT_COUNT_UNIT -- requirements
Module: bit_count_unit

---
 rtl/bit_count_unit_if.sv | 45 ++++
 rtl/bit_count_unit.sv | 187 ++++++++++++++++++
 tb/tb_bit_count_unit.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_count_unit_if.sv
// Handshake bundle for the bit count unit.
// The slave side is the unit itself; the master side is the producer/consumer.
interface bit_count_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  localparam int RES_W = $clog2(XLEN) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush,
    output in_valid,
    output in_op,
    output in_data,
    output in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_tag
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_op,
    input  in_data,
    input  in_tag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result,
    output out_tag
  );
endinterface

// File: rtl/bit_count_unit.sv
// Two-stage CLZ / CTZ / CPOP unit.
// S1 registers per-byte partials, S2 combines them into the result.
module bit_count_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic             clk,
  input logic             rst,
  bit_count_unit_if.slave bus
);
  localparam int RES_W = $clog2(XLEN) + 1;
  localparam int NB    = XLEN / 8;

  localparam logic [1:0] OP_CLZ = 2'b00;
  localparam logic [1:0] OP_CTZ = 2'b01;
  localparam logic [1:0] OP_POP = 2'b10;

  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [1:0]            s1_op_q, s1_op_d;
  logic [TAG_W-1:0]      s1_tag_q, s1_tag_d;
  logic [NB-1:0][3:0]    s1_lz_q, s1_lz_d;
  logic [NB-1:0][3:0]    s1_tz_q, s1_tz_d;
  logic [NB-1:0][3:0]    s1_pc_q, s1_pc_d;
  logic [NB-1:0]         s1_zb_q, s1_zb_d;
  logic [RES_W-1:0]      res_q, res_d;
  logic [TAG_W-1:0]      tag_q, tag_d;

  logic                  s1_adv, s2_adv;
  logic                  s1_load, s2_load;
  logic [RES_W-1:0]      clz_sum, ctz_sum;
  logic [RES_W-1:0]      pop_sum, comb_res;
  logic                  clz_done, ctz_done;

  function automatic logic [3:0] byte_lz(
    input logic [7:0] b
  );
    logic [3:0] n;
    logic       f;
    n = 4'd0;
    f = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (!f) begin
        if (b[k]) f = 1'b1;
        else      n = n + 4'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] byte_tz(
    input logic [7:0] b
  );
    logic [3:0] n;
    logic       f;
    n = 4'd0;
    f = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!f) begin
        if (b[k]) f = 1'b1;
        else      n = n + 4'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] byte_pc(
    input logic [7:0] b
  );
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'b000, b[k]};
    end
    return n;
  endfunction

  always_comb begin
    s2_adv  = !s2_valid_q || bus.out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    s1_load = s1_adv && bus.in_valid
              && !bus.flush;
    s2_load = s2_adv && s1_valid_q
              && !bus.flush;
  end

  assign bus.in_ready = s1_adv && !bus.flush;

  always_comb begin
    s1_op_d  = s1_op_q;
    s1_tag_d = s1_tag_q;
    s1_lz_d  = s1_lz_q;
    s1_tz_d  = s1_tz_q;
    s1_pc_d  = s1_pc_q;
    s1_zb_d  = s1_zb_q;
    if (s1_load) begin
      s1_op_d  = bus.in_op;
      s1_tag_d = bus.in_tag;
      for (int i = 0; i < NB; i++) begin
        s1_lz_d[i] = byte_lz(bus.in_data[8*i +: 8]);
        s1_tz_d[i] = byte_tz(bus.in_data[8*i +: 8]);
        s1_pc_d[i] = byte_pc(bus.in_data[8*i +: 8]);
        s1_zb_d[i] = (bus.in_data[8*i +: 8] == 8'h00);
      end
    end
  end

  // Leading/trailing counts accumulate through all-zero bytes
  // and stop after the first byte holding a one.
  always_comb begin
    clz_sum  = '0;
    ctz_sum  = '0;
    pop_sum  = '0;
    clz_done = 1'b0;
    ctz_done = 1'b0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (!clz_done) begin
        clz_sum  = clz_sum + RES_W'(s1_lz_q[i]);
        clz_done = !s1_zb_q[i];
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (!ctz_done) begin
        ctz_sum  = ctz_sum + RES_W'(s1_tz_q[i]);
        ctz_done = !s1_zb_q[i];
      end
      pop_sum = pop_sum + RES_W'(s1_pc_q[i]);
    end
  end

  always_comb begin
    comb_res = '0;
    unique case (1'b1)
      (s1_op_q == OP_CLZ): comb_res = clz_sum;
      (s1_op_q == OP_CTZ): comb_res = ctz_sum;
      (s1_op_q == OP_POP): comb_res = pop_sum;
      default:             comb_res = '0;
    endcase
  end

  always_comb begin
    res_d = res_q;
    tag_d = tag_q;
    if (s2_load) begin
      res_d = comb_res;
      tag_d = s1_tag_q;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_adv) s1_valid_d = bus.in_valid;
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (bus.flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      tag_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      tag_q      <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_op_q  <= s1_op_d;
    s1_tag_q <= s1_tag_d;
    s1_lz_q  <= s1_lz_d;
    s1_tz_q  <= s1_tz_d;
    s1_pc_q  <= s1_pc_d;
    s1_zb_q  <= s1_zb_d;
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = res_q;
  assign bus.out_tag    = tag_q;
endmodule

// File: tb/tb_bit_count_unit.sv
// Directed self-checking bench for bit_count_unit.
// Drives a 32-bit and a 64-bit instance.
module tb_bit_count_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  bit_count_unit_if #(.XLEN(32), .TAG_W(5)) b32();
  bit_count_unit_if #(.XLEN(64), .TAG_W(5)) b64();

  bit_count_unit #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk),
    .rst(rst),
    .bus(b32)
  );

  bit_count_unit #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk),
    .rst(rst),
    .bus(b64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic go();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    b32.flush     = 1'b0;
    b32.in_valid  = 1'b0;
    b32.in_op     = 2'b00;
    b32.in_data   = '0;
    b32.in_tag    = '0;
    b32.out_ready = 1'b1;
    b64.flush     = 1'b0;
    b64.in_valid  = 1'b0;
    b64.in_op     = 2'b00;
    b64.in_data   = '0;
    b64.in_tag    = '0;
    b64.out_ready = 1'b1;
    go();
    go();
    total++;
    if (b32.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%0b want=0",
               b32.out_valid);
    end
    total++;
    if (b32.out_result !== 6'd0) begin
      bad++;
      $display("FAIL rst_result got=%0d want=0",
               b32.out_result);
    end
    total++;
    if (b32.out_tag !== 5'd0) begin
      bad++;
      $display("FAIL rst_tag got=%0d want=0",
               b32.out_tag);
    end
    total++;
    if (b64.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid64 got=%0b want=0",
               b64.out_valid);
    end
    rst = 1'b0;
    #1;
    total++;
    if (b32.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_ready got=%0b want=1",
               b32.in_ready);
    end
    total++;
    if (b64.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_ready64 got=%0b want=1",
               b64.in_ready);
    end
    go();
  endtask

  task automatic test_clz_b2b();
    logic [31:0] dat [3];
    logic [4:0]  tg  [3];
    logic [5:0]  ex  [3];
    dat[0] = 32'h0000_0001; tg[0] = 5'd1; ex[0] = 6'd31;
    dat[1] = 32'h8000_0000; tg[1] = 5'd2; ex[1] = 6'd0;
    dat[2] = 32'h0000_0000; tg[2] = 5'd3; ex[2] = 6'd32;
    b32.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        b32.in_valid = 1'b1;
        b32.in_op    = 2'b00;
        b32.in_data  = dat[i];
        b32.in_tag   = tg[i];
      end else begin
        b32.in_valid = 1'b0;
      end
      #1;
      if (i < 3) begin
        total++;
        if (b32.in_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready[%0d] got=%0b want=1",
                   i, b32.in_ready);
        end
      end
      if (i >= 2) begin
        total++;
        if (b32.out_valid !== 1'b1 ||
            b32.out_result !== ex[i-2] ||
            b32.out_tag !== tg[i-2]) begin
          bad++;
          $display("FAIL b2b[%0d] got v=%0b r=%0d t=%0d want v=1 r=%0d t=%0d",
                   i - 2, b32.out_valid, b32.out_result,
                   b32.out_tag, ex[i-2], tg[i-2]);
        end
      end
      go();
    end
    total++;
    if (b32.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got=%0b want=0",
               b32.out_valid);
    end
  endtask

  task automatic test_ops();
    logic [1:0]  op  [8];
    logic [31:0] dat [8];
    logic [5:0]  ex  [8];
    op[0] = 2'b01; dat[0] = 32'h0001_0000; ex[0] = 6'd16;
    op[1] = 2'b10; dat[1] = 32'hF0F0_F0F0; ex[1] = 6'd16;
    op[2] = 2'b10; dat[2] = 32'hFFFF_FFFF; ex[2] = 6'd32;
    op[3] = 2'b11; dat[3] = 32'hDEAD_BEEF; ex[3] = 6'd0;
    op[4] = 2'b00; dat[4] = 32'hFFFF_FFFF; ex[4] = 6'd0;
    op[5] = 2'b01; dat[5] = 32'h0000_0000; ex[5] = 6'd32;
    op[6] = 2'b00; dat[6] = 32'h00F0_0000; ex[6] = 6'd8;
    op[7] = 2'b01; dat[7] = 32'h0000_0180; ex[7] = 6'd7;
    b32.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        b32.in_valid = 1'b1;
        b32.in_op    = op[i];
        b32.in_data  = dat[i];
        b32.in_tag   = 5'(i + 6);
      end else begin
        b32.in_valid = 1'b0;
      end
      #1;
      if (i >= 2) begin
        total++;
        if (b32.out_valid !== 1'b1 ||
            b32.out_result !== ex[i-2] ||
            b32.out_tag !== 5'(i + 4)) begin
          bad++;
          $display("FAIL ops[%0d] got v=%0b r=%0d t=%0d want v=1 r=%0d t=%0d",
                   i - 2, b32.out_valid, b32.out_result,
                   b32.out_tag, ex[i-2], i + 4);
        end
      end
      go();
    end
    total++;
    if (b32.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ops_drain got=%0b want=0",
               b32.out_valid);
    end
  endtask

  task automatic test_backpressure();
    b32.in_valid  = 1'b1;
    b32.in_op     = 2'b10;
    b32.in_data   = 32'h0000_000F;
    b32.in_tag    = 5'd4;
    b32.out_ready = 1'b0;
    go();
    b32.in_op   = 2'b00;
    b32.in_data = 32'h0000_0001;
    b32.in_tag  = 5'd5;
    #1;
    total++;
    if (b32.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready_s1 got=%0b want=1",
               b32.in_ready);
    end
    go();
    b32.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (b32.out_valid !== 1'b1 ||
          b32.out_tag !== 5'd4 ||
          b32.out_result !== 6'd4 ||
          b32.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%0b t=%0d r=%0d rdy=%0b want v=1 t=4 r=4 rdy=0",
                 k, b32.out_valid, b32.out_tag,
                 b32.out_result, b32.in_ready);
      end
      if (k < 2) go();
    end
    b32.out_ready = 1'b1;
    #1;
    total++;
    if (b32.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_ready got=%0b want=1",
               b32.in_ready);
    end
    go();
    #1;
    total++;
    if (b32.out_valid !== 1'b1 ||
        b32.out_tag !== 5'd5 ||
        b32.out_result !== 6'd31) begin
      bad++;
      $display("FAIL bp_second got v=%0b t=%0d r=%0d want v=1 t=5 r=31",
               b32.out_valid, b32.out_tag, b32.out_result);
    end
    go();
    #1;
    total++;
    if (b32.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain got=%0b want=0",
               b32.out_valid);
    end
    go();
  endtask

  task automatic test_flush();
    b32.in_valid  = 1'b1;
    b32.in_op     = 2'b10;
    b32.in_data   = 32'h0000_0003;
    b32.in_tag    = 5'd20;
    b32.out_ready = 1'b0;
    go();
    b32.in_tag = 5'd21;
    go();
    b32.in_tag = 5'd22;
    b32.flush  = 1'b1;
    #1;
    total++;
    if (b32.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL fl_ready got=%0b want=0",
               b32.in_ready);
    end
    total++;
    if (b32.out_valid !== 1'b1 ||
        b32.out_tag !== 5'd20) begin
      bad++;
      $display("FAIL fl_out got v=%0b t=%0d want v=1 t=20",
               b32.out_valid, b32.out_tag);
    end
    go();
    b32.flush     = 1'b0;
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (b32.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL fl_gone[%0d] got v=%0b t=%0d want v=0",
                 k, b32.out_valid, b32.out_tag);
      end
      go();
    end
    b32.in_valid = 1'b1;
    b32.in_op    = 2'b00;
    b32.in_data  = 32'h0001_0000;
    b32.in_tag   = 5'd23;
    go();
    b32.in_valid = 1'b0;
    go();
    #1;
    total++;
    if (b32.out_valid !== 1'b1 ||
        b32.out_result !== 6'd15 ||
        b32.out_tag !== 5'd23) begin
      bad++;
      $display("FAIL fl_next got v=%0b r=%0d t=%0d want v=1 r=15 t=23",
               b32.out_valid, b32.out_result, b32.out_tag);
    end
    go();
    #1;
    total++;
    if (b32.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL fl_drain got=%0b want=0",
               b32.out_valid);
    end
    go();
  endtask

  task automatic test_reset_mid();
    b32.out_ready = 1'b1;
    b32.in_valid  = 1'b1;
    b32.in_op     = 2'b10;
    b32.in_data   = 32'h0000_00FF;
    b32.in_tag    = 5'd16;
    go();
    b32.in_tag = 5'd17;
    go();
    b32.in_valid = 1'b0;
    #1;
    total++;
    if (b32.out_valid !== 1'b1 ||
        b32.out_result !== 6'd8 ||
        b32.out_tag !== 5'd16) begin
      bad++;
      $display("FAIL rm_pre got v=%0b r=%0d t=%0d want v=1 r=8 t=16",
               b32.out_valid, b32.out_result, b32.out_tag);
    end
    rst = 1'b1;
    #1;
    total++;
    if (b32.out_valid !== 1'b0 ||
        b32.out_result !== 6'd0 ||
        b32.out_tag !== 5'd0) begin
      bad++;
      $display("FAIL rm_async got v=%0b r=%0d t=%0d want v=0 r=0 t=0",
               b32.out_valid, b32.out_result, b32.out_tag);
    end
    go();
    rst = 1'b0;
    #1;
    total++;
    if (b32.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rm_ready got=%0b want=1",
               b32.in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      go();
      #1;
      total++;
      if (b32.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rm_stale[%0d] got v=%0b t=%0d want v=0",
                 k, b32.out_valid, b32.out_tag);
      end
    end
    go();
  endtask

  task automatic test_xlen64();
    logic [1:0]  op  [4];
    logic [63:0] dat [4];
    logic [6:0]  ex  [4];
    op[0] = 2'b00; dat[0] = 64'h0000_0000_8000_0000;
    ex[0] = 7'd32;
    op[1] = 2'b00; dat[1] = 64'h0;
    ex[1] = 7'd64;
    op[2] = 2'b01; dat[2] = 64'h8000_0000_0000_0000;
    ex[2] = 7'd63;
    op[3] = 2'b10; dat[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    ex[3] = 7'd64;
    b64.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        b64.in_valid = 1'b1;
        b64.in_op    = op[i];
        b64.in_data  = dat[i];
        b64.in_tag   = 5'(i + 24);
      end else begin
        b64.in_valid = 1'b0;
      end
      #1;
      if (i >= 2) begin
        total++;
        if (b64.out_valid !== 1'b1 ||
            b64.out_result !== ex[i-2] ||
            b64.out_tag !== 5'(i + 22)) begin
          bad++;
          $display("FAIL x64[%0d] got v=%0b r=%0d t=%0d want v=1 r=%0d t=%0d",
                   i - 2, b64.out_valid, b64.out_result,
                   b64.out_tag, ex[i-2], i + 22);
        end
      end
      go();
    end
    total++;
    if (b64.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL x64_drain got=%0b want=0",
               b64.out_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clz_b2b();
    test_ops();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_xlen64();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
